// File: rtl/bitcoin_pkg.sv
// Shared bitcoin hashing types and constants: controller FSM states, job sizing, SHA-256 round constants.
// Purely declarative; no timing or flow control of its own.
package bitcoin_pkg;

  localparam int NUM_NONCES = 16;
  localparam int HDR_WORDS  = 19;
  localparam int NONCE_W    = $clog2(NUM_NONCES);
  localparam int HDR_IDX_W  = $clog2(HDR_WORDS);

  typedef logic [NONCE_W-1:0]   nonce_idx_t;
  typedef logic [HDR_IDX_W-1:0] hdr_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE,
    SCAN,
    REPORT
  } ctrl_state_t;

  localparam logic [0:63][31:0] SHA256_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sha256_k(input logic [5:0] round);
    return SHA256_K[round];
  endfunction

endpackage

// File: rtl/hash_min_tracker.sv
// Running unsigned minimum of sampled hash words plus a sticky below-target flag.
// Updates on the sampling edge; no backpressure (sample is a strobe).
module hash_min_tracker
  import bitcoin_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        sample,
  input  logic [31:0] word,
  input  nonce_idx_t  index,
  input  logic [31:0] target,
  output logic [31:0] min_value,
  output nonce_idx_t  min_index,
  output logic        found
);

  logic have;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      have      <= 1'b0;
      min_value <= '0;
      min_index <= '0;
      found     <= 1'b0;
    end else if (sample) begin
      have <= 1'b1;
      // Strict less-than keeps the earlier nonce on ties.
      if (!have || (word < min_value)) begin
        min_value <= word;
        min_index <= index;
      end
      if (word < target) begin
        found <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_job_controller.sv
// Loads a block header into shared memory, kicks the hasher, scans results for the minimum hash.
// Header accepted one word per cycle in IDLE/LOAD (stalled elsewhere); result held until result_ready.
module hash_job_controller
  import bitcoin_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] target,
  output logic        hash_start,
  input  logic        hash_done,
  output logic        mem_own,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        result_found,
  output nonce_idx_t  result_nonce,
  output logic [31:0] result_hash,
  output logic        result_timeout
);

  localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam hdr_idx_t         HDR_LAST   = hdr_idx_t'(HDR_WORDS - 1);
  localparam nonce_idx_t       NONCE_LAST = nonce_idx_t'(NUM_NONCES - 1);

  ctrl_state_t      state;
  hdr_idx_t         idx;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      target_q;
  nonce_idx_t       rd_idx;
  nonce_idx_t       pend_idx;
  logic             addr_vld;
  logic             pend_vld;
  logic             accept;
  logic             track_clear;
  logic             track_sample;

  assign accept       = in_valid && in_ready;
  assign track_clear  = (state == START);
  // Read data for the address issued two edges ago is on mem_read_data now.
  assign track_sample = (state == SCAN) && pend_vld;

  hash_min_tracker u_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (track_clear),
    .sample    (track_sample),
    .word      (mem_read_data),
    .index     (pend_idx),
    .target    (target_q),
    .min_value (result_hash),
    .min_index (result_nonce),
    .found     (result_found)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      in_ready       <= 1'b0;
      hash_start     <= 1'b0;
      mem_own        <= 1'b1;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      result_valid   <= 1'b0;
      result_timeout <= 1'b0;
      idx            <= '0;
      wait_cnt       <= '0;
      target_q       <= '0;
      rd_idx         <= '0;
      pend_idx       <= '0;
      addr_vld       <= 1'b0;
      pend_vld       <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      hash_start <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          mem_own  <= 1'b1;
          if (accept) begin
            mem_we         <= 1'b1;
            mem_addr       <= message_addr;
            mem_write_data <= in_data;
            target_q       <= target;
            idx            <= hdr_idx_t'(1);
            state          <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            mem_we         <= 1'b1;
            mem_addr       <= message_addr + 16'(idx);
            mem_write_data <= in_data;
            idx            <= idx + hdr_idx_t'(1);
            if (idx == HDR_LAST) begin
              in_ready <= 1'b0;
              state    <= START;
            end
          end
        end
        START: begin
          hash_start <= 1'b1;
          wait_cnt   <= '0;
          state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          mem_own <= 1'b0;
          if (hash_done) begin
            mem_own  <= 1'b1;
            mem_addr <= output_addr;
            rd_idx   <= '0;
            addr_vld <= 1'b1;
            pend_vld <= 1'b0;
            state    <= SCAN;
          end else if (wait_cnt == CNT_LAST) begin
            // Reclaim the bus so the next job can load even if the hasher is hung.
            mem_own        <= 1'b1;
            result_timeout <= 1'b1;
            result_valid   <= 1'b1;
            state          <= REPORT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        SCAN: begin
          pend_vld <= addr_vld;
          pend_idx <= rd_idx;
          if (addr_vld) begin
            if (rd_idx == NONCE_LAST) begin
              addr_vld <= 1'b0;
            end else begin
              rd_idx   <= rd_idx + nonce_idx_t'(1);
              mem_addr <= output_addr + 16'(rd_idx) + 16'd1;
            end
          end
          if (pend_vld && (pend_idx == NONCE_LAST)) begin
            result_valid <= 1'b1;
            state        <= REPORT;
          end
        end
        REPORT: begin
          if (result_ready) begin
            result_valid   <= 1'b0;
            result_timeout <= 1'b0;
            in_ready       <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_job_controller.sv
// Directed bench for hash_job_controller: header load, start/done, result scan, timeout and reset abort.
// Shared memory and hasher are modelled here; results come from a per-test table at output_addr.
module tb_hash_job_controller;
  import bitcoin_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] target;
  logic        hash_start;
  logic        hash_done;
  logic        mem_own;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        result_valid;
  logic        result_ready;
  logic        result_found;
  nonce_idx_t  result_nonce;
  logic [31:0] result_hash;
  logic        result_timeout;

  always #5 clk = ~clk;

  hash_job_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .target         (target),
    .hash_start     (hash_start),
    .hash_done      (hash_done),
    .mem_own        (mem_own),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_found   (result_found),
    .result_nonce   (result_nonce),
    .result_hash    (result_hash),
    .result_timeout (result_timeout)
  );

  logic [31:0] mem [0:65535];
  logic [31:0] res [0:15];
  wire  [15:0] rd_off = mem_addr - output_addr;
  logic [15:0] wa [$];
  logic [31:0] wd [$];
  int          wc [$];
  int          cyc = 0;
  int          n_start = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_own && mem_we) mem[mem_addr] <= mem_write_data;
    if (rd_off < 16'd16) mem_read_data <= res[rd_off[3:0]];
    else                 mem_read_data <= mem[mem_addr];
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_write_data);
      wc.push_back(cyc);
    end
    if (hash_start) n_start <= n_start + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  // Target is scrambled after word 0 to show it was latched at the first accept.
  task automatic send_hdr(input logic [31:0] base, input bit gaps, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      @(negedge clk);
      if (i == 0) target = 32'h0;
      if (gaps && i != nwords - 1) begin
        in_valid  = 1'b0;
        hash_done = (i == 4);
        @(negedge clk);
        hash_done = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  // Entered in the START cycle; done raised after two idle WAIT_DONE cycles.
  task automatic run_to_result(input string tag);
    int n = 0;
    @(negedge clk);
    chk({tag, "_start_hi"}, {hash_start, mem_own}, 2'b11);
    @(negedge clk);
    chk({tag, "_start_lo"}, {hash_start, mem_own}, 2'b00);
    @(negedge clk);
    chk({tag, "_own_wait"}, mem_own, 0);
    hash_done = 1'b1;
    @(negedge clk);
    hash_done = 1'b0;
    while (!result_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_scan_latency"}, n, 17);
    chk({tag, "_own_back"}, mem_own, 1);
  endtask

  task automatic check_writes(input string tag, input int n0, input logic [15:0] a0,
                              input logic [31:0] d0, input int nexp, input int span);
    int nw  = wa.size() - n0;
    int bad = 0;
    chk({tag, "_nwrites"}, nw, nexp);
    if (nw >= nexp) begin
      for (int i = 0; i < nexp; i++)
        if (wa[n0+i] !== 16'(a0 + 16'(i)) || wd[n0+i] !== d0 + 32'(i)) bad++;
      chk({tag, "_wr_addr_data"}, bad, 0);
      chk({tag, "_wr_span"}, wc[n0+nexp-1] - wc[n0], span);
    end
  endtask

  task automatic finish_result(input string tag, input logic found, input logic [3:0] nonce,
                               input logic [31:0] hash, input logic tmo, input bit chk_hash,
                               input int hold);
    for (int k = 0; k <= hold; k++) begin
      chk({tag, "_flags"}, {result_valid, result_found, result_timeout}, {1'b1, found, tmo});
      if (chk_hash) chk({tag, "_min"}, {result_nonce, result_hash}, {nonce, hash});
      if (k < hold) @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({tag, "_released"}, {result_valid, result_timeout, in_ready}, 3'b001);
  endtask

  int n0;
  int s0;
  int n;

  initial begin
    reset_n      = 1'b0;
    message_addr = 16'h0;
    output_addr  = 16'h0;
    in_valid     = 1'b0;
    in_data      = 32'h0;
    target       = 32'h0;
    hash_done    = 1'b0;
    result_ready = 1'b0;
    for (int i = 0; i < 16; i++) res[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {in_ready, hash_start, mem_we, result_valid, result_found, result_timeout, mem_own},
        7'b0000001);
    chk("reset_data", {mem_addr, mem_write_data, result_nonce, result_hash}, 84'h0);
    reset_n = 1'b1;

    // Job 1: back-to-back header, descending results, nothing below target.
    message_addr = 16'h0100;
    output_addr  = 16'h0200;
    for (int i = 0; i < 16; i++) res[i] = 32'hF0 - 32'(i);
    target = 32'h10;
    wait_ready("t1");
    n0 = wa.size();
    s0 = n_start;
    send_hdr(32'h1000, 1'b0, 19);
    run_to_result("t1");
    check_writes("t1", n0, 16'h0100, 32'h1000, 19, 18);
    chk("t1_one_start", n_start - s0, 1);
    finish_result("t1", 1'b0, 4'd15, 32'hE1, 1'b0, 1'b1, 2);

    // Job 2: gapped header wrapping the address space, tie on the minimum, stray hash_done in LOAD.
    message_addr = 16'hFFF0;
    output_addr  = 16'h0010;
    for (int i = 0; i < 16; i++) res[i] = 32'hFFFF_FFFF;
    res[3] = 32'h5;
    res[9] = 32'h5;
    target = 32'h6;
    wait_ready("t2");
    n0 = wa.size();
    s0 = n_start;
    send_hdr(32'h2000, 1'b1, 19);
    run_to_result("t2");
    check_writes("t2", n0, 16'hFFF0, 32'h2000, 19, 36);
    chk("t2_one_start", n_start - s0, 1);
    finish_result("t2", 1'b1, 4'd3, 32'h5, 1'b0, 1'b1, 20);

    // Job 3: hasher never answers.
    message_addr = 16'h0400;
    output_addr  = 16'h0500;
    target = 32'h7;
    wait_ready("t3");
    s0 = n_start;
    send_hdr(32'h3000, 1'b0, 19);
    n = 0;
    while (!result_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t3_timeout_latency", n, 9);
    chk("t3_one_start", n_start - s0, 1);
    finish_result("t3", 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 3);

    // Job 4: reset after word 10 aborts the load.
    message_addr = 16'h0600;
    wait_ready("t4");
    n0 = wa.size();
    s0 = n_start;
    send_hdr(32'h4000, 1'b0, 11);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t4_reset_ctrl", {in_ready, hash_start, mem_we, result_valid, mem_own}, 5'b00001);
    chk("t4_reset_addr", mem_addr, 16'h0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check_writes("t4", n0, 16'h0600, 32'h4000, 11, 10);
    chk("t4_no_start", n_start - s0, 0);
    chk("t4_idle", {in_ready, mem_we, mem_own}, 3'b101);

    // Job 5: full job after the abort; result window wraps, tie and equal-to-target.
    message_addr = 16'h0300;
    output_addr  = 16'hFFFC;
    for (int i = 0; i < 16; i++) res[i] = 32'h1000;
    res[5]  = 32'h800;
    res[12] = 32'h800;
    target = 32'h800;
    wait_ready("t5");
    n0 = wa.size();
    s0 = n_start;
    send_hdr(32'h5000, 1'b0, 19);
    run_to_result("t5");
    check_writes("t5", n0, 16'h0300, 32'h5000, 19, 18);
    chk("t5_one_start", n_start - s0, 1);
    finish_result("t5", 1'b0, 4'd5, 32'h800, 1'b0, 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d assertions evaluated", n_assert);
    $fatal(1, "watchdog expired");
  end

endmodule
